// File: rtl/draw_arbiter_pkg.sv
// Shared types and constants for the draw arbiter.
// Optional build macro: DRAW_ARBITER_STATS_EN (per-requester completed-shape counters).
package draw_arbiter_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam int unsigned STAT_W = 16;

endpackage

// File: rtl/draw_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit at or above ptr, wrapping.
module draw_arbiter_rr_pick
    import draw_arbiter_pkg::*;
#(
    parameter  int unsigned REQ_CNT = 4,
    localparam int unsigned IDXW    = $clog2(REQ_CNT)
) (
    input  logic [REQ_CNT-1:0] req_i,
    input  logic [IDXW-1:0]    ptr_i,
    output logic               valid_o,
    output logic [IDXW-1:0]    winner_o
);

    int idx;

    // Scan from the farthest offset down so the nearest hit to ptr is assigned last.
    always_comb begin
        valid_o  = 1'b0;
        winner_o = '0;
        idx      = 0;
        for (int k = int'(REQ_CNT) - 1; k >= 0; k--) begin
            idx = int'(ptr_i) + k;
            if (idx >= int'(REQ_CNT)) begin
                idx = idx - int'(REQ_CNT);
            end
            if (req_i[IDXW'(idx)]) begin
                valid_o  = 1'b1;
                winner_o = IDXW'(idx);
            end
        end
    end

endmodule

// File: rtl/draw_arbiter.sv
// Round-robin arbiter sharing one triangle engine among REQ_CNT shape producers.
// Optional build macro: DRAW_ARBITER_STATS_EN enables 16-bit completed-shape counters
// on stat_cnt; when undefined stat_cnt is tied to zero.
module draw_arbiter
    import draw_arbiter_pkg::*;
#(
    parameter  int unsigned CORDW   = 16,
    parameter  int unsigned CIDXW   = 4,
    parameter  int unsigned REQ_CNT = 4,
    localparam int unsigned IDXW    = $clog2(REQ_CNT)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [REQ_CNT-1:0]          req,
    input  logic [REQ_CNT*3*CORDW-1:0]  req_vx,
    input  logic [REQ_CNT*3*CORDW-1:0]  req_vy,
    input  logic [REQ_CNT*CIDXW-1:0]    req_cidx,
    output logic [REQ_CNT-1:0]          gnt,
    output logic [REQ_CNT-1:0]          req_done,
    output logic                        eng_start,
    output logic signed [CORDW-1:0]     eng_x0,
    output logic signed [CORDW-1:0]     eng_y0,
    output logic signed [CORDW-1:0]     eng_x1,
    output logic signed [CORDW-1:0]     eng_y1,
    output logic signed [CORDW-1:0]     eng_x2,
    output logic signed [CORDW-1:0]     eng_y2,
    output logic [CIDXW-1:0]            eng_cidx,
    input  logic                        eng_done,
    output logic [IDXW-1:0]             owner,
    output logic                        busy,
    output logic [REQ_CNT*STAT_W-1:0]   stat_cnt
);

    state_t                  state_q;
    logic [IDXW-1:0]         rr_ptr_q;
    logic [IDXW-1:0]         owner_q;
    logic [REQ_CNT-1:0]      gnt_q;
    logic [REQ_CNT-1:0]      req_done_q;
    logic                    eng_start_q;
    logic signed [CORDW-1:0] x0_q, y0_q, x1_q, y1_q, x2_q, y2_q;
    logic [CIDXW-1:0]        cidx_q;

    logic                    pick_valid;
    logic [IDXW-1:0]         pick_idx;
    logic [CORDW-1:0]        sel_x0, sel_y0, sel_x1, sel_y1, sel_x2, sel_y2;
    logic [CIDXW-1:0]        sel_cidx;

    draw_arbiter_rr_pick #(
        .REQ_CNT (REQ_CNT)
    ) u_rr_pick (
        .req_i    (req),
        .ptr_i    (rr_ptr_q),
        .valid_o  (pick_valid),
        .winner_o (pick_idx)
    );

    // Operand mux for the candidate winner; vertex k of requester i sits at slice i*3+k.
    always_comb begin
        sel_x0   = req_vx[(int'(pick_idx) * 3 + 0) * int'(CORDW) +: CORDW];
        sel_x1   = req_vx[(int'(pick_idx) * 3 + 1) * int'(CORDW) +: CORDW];
        sel_x2   = req_vx[(int'(pick_idx) * 3 + 2) * int'(CORDW) +: CORDW];
        sel_y0   = req_vy[(int'(pick_idx) * 3 + 0) * int'(CORDW) +: CORDW];
        sel_y1   = req_vy[(int'(pick_idx) * 3 + 1) * int'(CORDW) +: CORDW];
        sel_y2   = req_vy[(int'(pick_idx) * 3 + 2) * int'(CORDW) +: CORDW];
        sel_cidx = req_cidx[int'(pick_idx) * int'(CIDXW) +: CIDXW];
    end

    // Arbitration FSM: grant and latch in IDLE, wait for engine completion in WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            gnt_q       <= '0;
            req_done_q  <= '0;
            eng_start_q <= 1'b0;
            x0_q        <= '0;
            y0_q        <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
            x2_q        <= '0;
            y2_q        <= '0;
            cidx_q      <= '0;
        end else begin
            gnt_q       <= '0;
            req_done_q  <= '0;
            eng_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        x0_q        <= sel_x0;
                        y0_q        <= sel_y0;
                        x1_q        <= sel_x1;
                        y1_q        <= sel_y1;
                        x2_q        <= sel_x2;
                        y2_q        <= sel_y2;
                        cidx_q      <= sel_cidx;
                        owner_q     <= pick_idx;
                        gnt_q       <= REQ_CNT'(1) << pick_idx;
                        eng_start_q <= 1'b1;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    if (eng_done) begin
                        req_done_q <= REQ_CNT'(1) << owner_q;
                        rr_ptr_q   <= (owner_q == IDXW'(REQ_CNT - 1)) ? '0 : owner_q + IDXW'(1);
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DRAW_ARBITER_STATS_EN
    logic [REQ_CNT*STAT_W-1:0] stat_q;

    // Per-requester completed-shape counters, wrapping at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q <= '0;
        end else begin
            for (int i = 0; i < int'(REQ_CNT); i++) begin
                if (req_done_q[i]) begin
                    stat_q[i*int'(STAT_W) +: STAT_W] <= stat_q[i*int'(STAT_W) +: STAT_W] + STAT_W'(1);
                end
            end
        end
    end

    assign stat_cnt = stat_q;
`else
    assign stat_cnt = '0;
`endif

    assign gnt       = gnt_q;
    assign req_done  = req_done_q;
    assign eng_start = eng_start_q;
    assign eng_x0    = x0_q;
    assign eng_y0    = y0_q;
    assign eng_x1    = x1_q;
    assign eng_y1    = y1_q;
    assign eng_x2    = x2_q;
    assign eng_y2    = y2_q;
    assign eng_cidx  = cidx_q;
    assign owner     = owner_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_draw_arbiter.sv
// Directed bench for draw_arbiter (REQ_CNT=4, CORDW=16, CIDXW=4).
module tb_draw_arbiter;

    localparam int unsigned CORDW   = 16;
    localparam int unsigned CIDXW   = 4;
    localparam int unsigned REQ_CNT = 4;

    logic                       clk;
    logic                       rst;
    logic [REQ_CNT-1:0]         req;
    logic [REQ_CNT*3*CORDW-1:0] req_vx;
    logic [REQ_CNT*3*CORDW-1:0] req_vy;
    logic [REQ_CNT*CIDXW-1:0]   req_cidx;
    logic [REQ_CNT-1:0]         gnt;
    logic [REQ_CNT-1:0]         req_done;
    logic                       eng_start;
    logic signed [CORDW-1:0]    eng_x0, eng_y0, eng_x1, eng_y1, eng_x2, eng_y2;
    logic [CIDXW-1:0]           eng_cidx;
    logic                       eng_done;
    logic [1:0]                 owner;
    logic                       busy;
    logic [REQ_CNT*16-1:0]      stat_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int gnt_total;
    int done_total;

    draw_arbiter #(
        .CORDW   (CORDW),
        .CIDXW   (CIDXW),
        .REQ_CNT (REQ_CNT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_vx    (req_vx),
        .req_vy    (req_vy),
        .req_cidx  (req_cidx),
        .gnt       (gnt),
        .req_done  (req_done),
        .eng_start (eng_start),
        .eng_x0    (eng_x0),
        .eng_y0    (eng_y0),
        .eng_x1    (eng_x1),
        .eng_y1    (eng_y1),
        .eng_x2    (eng_x2),
        .eng_y2    (eng_y2),
        .eng_cidx  (eng_cidx),
        .eng_done  (eng_done),
        .owner     (owner),
        .busy      (busy),
        .stat_cnt  (stat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int i, input logic [15:0] x0, input logic [15:0] y0,
                           input logic [15:0] x1, input logic [15:0] y1,
                           input logic [15:0] x2, input logic [15:0] y2, input logic [3:0] c);
        req_vx[(i*3+0)*16 +: 16] = x0;
        req_vx[(i*3+1)*16 +: 16] = x1;
        req_vx[(i*3+2)*16 +: 16] = x2;
        req_vy[(i*3+0)*16 +: 16] = y0;
        req_vy[(i*3+1)*16 +: 16] = y1;
        req_vy[(i*3+2)*16 +: 16] = y2;
        req_cidx[i*4 +: 4]       = c;
    endtask

    // Full single-shape transaction: request, drop, complete, one idle cycle.
    task automatic serve(input logic [3:0] r, input int exp_idx, input string tag);
        logic [3:0] e;
        e = 4'(1 << exp_idx);
        req = r;
        tick();
        check({tag, "_gnt"}, 64'(gnt), 64'(e));
        check({tag, "_owner"}, 64'(owner), 64'(exp_idx));
        req = '0;
        tick();
        eng_done = 1'b1;
        tick();
        check({tag, "_done"}, 64'(req_done), 64'(e));
        eng_done = 1'b0;
        tick();
    endtask

    task automatic accum();
        gnt_total  += $countones(gnt);
        done_total += $countones(req_done);
    endtask

    initial begin
        int exp_order [5];
        logic [3:0] e;
        logic [63:0] exp_stat;

        exp_order = '{0, 1, 2, 3, 0};
        rst = 1'b1; req = '0; req_vx = '0; req_vy = '0; req_cidx = '0; eng_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset values
        check("rst_gnt", 64'(gnt), 64'(0));
        check("rst_done", 64'(req_done), 64'(0));
        check("rst_start", 64'(eng_start), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_owner", 64'(owner), 64'(0));
        check("rst_x0", 64'(eng_x0), 64'(0));
        check("rst_stat", stat_cnt, 64'(0));

        // Single request from requester 1
        set_ops(1, 16'd60, 16'd20, 16'd280, 16'd80, 16'd160, 16'd164, 4'd3);
        req = 4'b0010;
        tick();
        check("single_gnt", 64'(gnt), 64'(4'b0010));
        check("single_start", 64'(eng_start), 64'(1));
        check("single_owner", 64'(owner), 64'(1));
        check("single_busy", 64'(busy), 64'(1));
        check("single_x0", 64'(eng_x0), 64'(60));
        check("single_y0", 64'(eng_y0), 64'(20));
        check("single_x1", 64'(eng_x1), 64'(280));
        check("single_y1", 64'(eng_y1), 64'(80));
        check("single_x2", 64'(eng_x2), 64'(160));
        check("single_y2", 64'(eng_y2), 64'(164));
        check("single_cidx", 64'(eng_cidx), 64'(3));
        req = '0;
        tick();
        check("single_gnt_clr", 64'(gnt), 64'(0));
        check("single_start_clr", 64'(eng_start), 64'(0));
        check("single_busy_wait", 64'(busy), 64'(1));
        check("single_no_early_done", 64'(req_done), 64'(0));
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        check("single_done", 64'(req_done), 64'(4'b0010));
        check("single_busy_fall", 64'(busy), 64'(0));
        tick();
        check("single_done_pulse", 64'(req_done), 64'(0));

        // eng_done in IDLE is ignored
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        check("idle_done_ignored", 64'(req_done), 64'(0));
        check("idle_busy", 64'(busy), 64'(0));

        // All requesting continuously from reset: order 0,1,2,3,0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        gnt_total = 0;
        done_total = 0;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            e = 4'(1 << exp_order[k]);
            tick();
            accum();
            check($sformatf("rr_gnt%0d", k), 64'(gnt), 64'(e));
            check($sformatf("rr_owner%0d", k), 64'(owner), 64'(exp_order[k]));
            repeat (9) begin
                tick();
                accum();
            end
            eng_done = 1'b1;
            tick();
            accum();
            eng_done = 1'b0;
            check($sformatf("rr_done%0d", k), 64'(req_done), 64'(e));
        end
        req = '0;
        tick();
        accum();
        check("rr_gnt_total", 64'(gnt_total), 64'(5));
        check("rr_done_total", 64'(done_total), 64'(5));

        // Pointer wrap: serve 3, then 1001 -> 0, then 1001 -> 3
        serve(4'b1000, 3, "wrap_a");
        serve(4'b1001, 0, "wrap_b");
        serve(4'b1001, 3, "wrap_c");

        // Operand change after grant does not reach the engine
        set_ops(2, 16'd22, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 4'd11);
        req = 4'b0100;
        tick();
        check("opchg_gnt", 64'(gnt), 64'(4'b0100));
        check("opchg_x0_lat", 64'(eng_x0), 64'(22));
        req = '0;
        req_vx[(2*3+0)*16 +: 16] = 16'd98;
        tick();
        check("opchg_x0_hold", 64'(eng_x0), 64'(22));
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        tick();
        check("opchg_x0_idle", 64'(eng_x0), 64'(22));
        req = 4'b0100;
        tick();
        check("opchg_x0_new", 64'(eng_x0), 64'(98));
        req = '0;
        tick();
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        tick();

        // Reset during WAIT
        req = 4'b0010;
        tick();
        check("abort_gnt", 64'(gnt), 64'(4'b0010));
        req = '0;
        repeat (3) tick();
        check("abort_busy_pre", 64'(busy), 64'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_gnt_clr", 64'(gnt), 64'(0));
        check("abort_done", 64'(req_done), 64'(0));
        check("abort_start", 64'(eng_start), 64'(0));
        check("abort_owner", 64'(owner), 64'(0));
        check("abort_x0", 64'(eng_x0), 64'(0));
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        check("abort_stray_done", 64'(req_done), 64'(0));
        tick();
        check("abort_stray_done2", 64'(req_done), 64'(0));
        check("abort_stat", stat_cnt, 64'(0));

        // Completed-shape statistics
        for (int k = 0; k < 5; k++) serve(4'b0010, 1, $sformatf("stat1_%0d", k));
        for (int k = 0; k < 2; k++) serve(4'b1000, 3, $sformatf("stat3_%0d", k));
`ifdef DRAW_ARBITER_STATS_EN
        exp_stat = {16'd2, 16'd0, 16'd5, 16'd0};
`else
        exp_stat = 64'd0;
`endif
        check("stat_cnt", stat_cnt, exp_stat);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/draw_arbiter.md
Name: draw_arbiter

Overview:
- Shares one triangle-drawing engine between REQ_CNT independent shape producers using round-robin arbitration.
- Latches the winning requester's three vertices and colour index, then pulses the engine start.
- Waits for engine completion, then returns a one-cycle completion pulse to the owning requester.
- Sits between per-layer render sequencers and the single draw engine feeding the framebuffer write path.

Parameters:
- CORDW, 16, signed coordinate width (bits)
- CIDXW, 4, colour index width (bits)
- REQ_CNT, 4, number of requesters (2..8)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req  in  REQ_CNT  per-requester draw request, level
- req_vx  in  REQ_CNT*3*CORDW  packed signed x0,x1,x2 per requester; requester i at slice i
- req_vy  in  REQ_CNT*3*CORDW  packed signed y0,y1,y2 per requester
- req_cidx  in  REQ_CNT*CIDXW  colour index per requester
- gnt  out  REQ_CNT  one-hot, one-cycle pulse: request accepted, operands latched
- req_done  out  REQ_CNT  one-hot, one-cycle pulse: owner's shape finished
- eng_start  out  1  engine start, one-cycle pulse
- eng_x0, eng_y0, eng_x1, eng_y1, eng_x2, eng_y2  out  CORDW each  latched signed vertices
- eng_cidx  out  CIDXW  latched colour index
- eng_done  in  1  engine completion, one-cycle pulse
- owner  out  $clog2(REQ_CNT)  index of the current or last winner
- busy  out  1  high when not in IDLE
- stat_cnt  out  REQ_CNT*16  completed-shape counters (see Optional Feature)

Behaviour:
- Reset values: state IDLE, rr_ptr=0, owner=0, gnt=0, req_done=0, eng_start=0, eng_* vertices and cidx=0, busy=0, stat_cnt=0.
- States: IDLE, WAIT (defined in the package).
- IDLE:
  - If req!=0, the winner is the first set bit of req searching from rr_ptr upward, wrapping at REQ_CNT.
  - Same cycle (registered): latch winner's vertices and cidx, owner<=winner, gnt[winner]<=1, eng_start<=1, state<=WAIT.
  - If req==0, remain in IDLE.
- WAIT:
  - gnt and eng_start clear after one cycle.
  - eng_done is sampled only in WAIT. On eng_done: req_done[owner]<=1 for one cycle, rr_ptr<=(owner+1) mod REQ_CNT, state<=IDLE.
- Latency and throughput:
  - req high in IDLE at cycle N gives gnt and eng_start high at N+1.
  - eng_done at cycle M gives req_done at M+1.
  - The earliest next gnt is M+2, because IDLE lasts at least one cycle.
- Handshake:
  - A requester holds req and operands stable until its gnt and must drop req the cycle after gnt.
  - req still high in IDLE after req_done is treated as a new request.
  - req withdrawn before gnt is legal and is not granted.
  - Operands may change freely after gnt; latched copies drive the engine.
- Fairness: after requester i is served, i has lowest priority. With all requesters continuously requesting, grant order is 0,1,2,...,REQ_CNT-1,0.
- busy=(state!=IDLE), combinational from state.
- eng_done while in IDLE is ignored; no req_done is produced.
- Reset mid-draw: immediate return to IDLE with all outputs at reset values. The engine shares rst and aborts as well. No req_done is issued for the aborted shape.
- Widths: vertices pass through unmodified; no scaling or clipping.

Optional Feature:
- Macro: DRAW_ARBITER_STATS_EN.
- Defined: stat_cnt slice i is a 16-bit counter incremented on each req_done[i]. It wraps 0xFFFF->0, and is cleared by rst.
- Undefined: stat_cnt is constant 0 and no counter logic is generated. The port list is unchanged.

Decomposition:
- Package draw_arbiter_pkg:
  - state enum type (IDLE, WAIT)
  - STAT_W=16 constant
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: valid, winner index.
  - Parameterised by REQ_CNT.

Test Plan:
- Single request: req=4'b0010 with vertices (60,20),(280,80),(160,164), cidx=3 -> gnt=4'b0010 and eng_start one cycle later; eng_* match the inputs; owner=1; after eng_done, req_done=4'b0010 one cycle later; busy falls.
- All requesting continuously (req=4'b1111), engine completing 10 cycles after each start -> grant order 0,1,2,3,0; exactly one gnt and one req_done per shape.
- Pointer wrap: last served owner=3, then req=4'b1001 -> requester 0 wins; then owner=0 with req=4'b1001 -> requester 3 wins.
- Operand change after gnt: requester 2's vx0 changes from 22 to 98 the cycle after gnt -> eng_x0 stays 22 until the next grant.
- Reset during WAIT (3 cycles after eng_start) -> next cycle busy=0, gnt=0, req_done=0, eng_start=0, owner=0. A stray eng_done afterwards produces no req_done.
- DRAW_ARBITER_STATS_EN defined: 5 shapes for requester 1 and 2 for requester 3 -> stat_cnt slices 1=5, 3=2, others 0. Undefined: stat_cnt stays 0.
